booth_mult_seq: RTL

//   Sequential radix-2 Booth multiplier controller. It accepts one signed

---
 rtl/booth_mult_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one multiplier bit pair per clock into a 2*WIDE accumulator.
// Optional BOOTH_EARLY_EXIT_EN ends the scan once all remaining multiplier bits are equal.
module booth_mult_seq #(
  parameter int WIDE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDE-1:0]   x,
  input  logic [WIDE-1:0]   y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WIDE-1:0] product,
  output logic              busy
);

  localparam int PW = 2 * WIDE;
  localparam int CW = $clog2(WIDE + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDE-1:0] x_q;
  logic [WIDE:0]   y_q;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q;
  logic [CW-1:0]   cnt_q;

  logic [1:0]      pair;
  logic [PW-1:0]   sx, addend, operand;
  logic            sub;
  logic            last_pair;

  // y_q carries the implicit y[-1]=0 in bit 0, so pair i sits at y_q[i+1:i]
  assign pair   = y_q[cnt_q +: 2];
  assign sx     = {{WIDE{x_q[WIDE-1]}}, x_q};
  assign addend = sx << cnt_q;
  assign sub    = (pair == 2'b10);

  always_comb begin
    operand = '0;
    if (pair == 2'b01) operand = addend;
    else if (sub)      operand = ~addend;
  end

  // Single shared adder; subtraction uses the inverted addend plus carry-in.
  assign acc_d = acc_q + operand + {{(PW-1){1'b0}}, sub};

`ifdef BOOTH_EARLY_EXIT_EN
  logic [WIDE:0] y_rest;
  // Bits above the current pair all equal -> every later pair is 00/11.
  assign y_rest    = $signed(y_q) >>> (cnt_q + CW'(1));
  assign last_pair = (cnt_q == LAST) || (y_rest == '0) || (&y_rest);
`else
  assign last_pair = (cnt_q == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_pair) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    product   = product_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          x_q   <= x;
          y_q   <= {y, 1'b0};
          acc_q <= '0;
          cnt_q <= '0;
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_pair) product_q <= acc_d;
        end
        default: ;
      endcase
    end
  end

endmodule
